// File: rtl/ps2_text_pkg.sv
// Shared constants for the PS/2 text line buffer: scan codes, char_rom
// addresses and the scan-code to character translation.
package ps2_text_pkg;

  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_BKSP  = 8'h66;

  localparam logic [7:0] SC_A = 8'h1C;
  localparam logic [7:0] SC_B = 8'h32;
  localparam logic [7:0] SC_C = 8'h21;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24;
  localparam logic [7:0] SC_F = 8'h2B;
  localparam logic [7:0] SC_G = 8'h34;
  localparam logic [7:0] SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43;
  localparam logic [7:0] SC_J = 8'h3B;
  localparam logic [7:0] SC_K = 8'h42;
  localparam logic [7:0] SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A;
  localparam logic [7:0] SC_N = 8'h31;
  localparam logic [7:0] SC_O = 8'h44;
  localparam logic [7:0] SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15;
  localparam logic [7:0] SC_R = 8'h2D;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C;
  localparam logic [7:0] SC_V = 8'h2A;
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35;
  localparam logic [7:0] SC_Z = 8'h1A;

  localparam logic [7:0] SC_0 = 8'h45;
  localparam logic [7:0] SC_1 = 8'h16;
  localparam logic [7:0] SC_2 = 8'h1E;
  localparam logic [7:0] SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25;
  localparam logic [7:0] SC_5 = 8'h2E;
  localparam logic [7:0] SC_6 = 8'h36;
  localparam logic [7:0] SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E;
  localparam logic [7:0] SC_9 = 8'h46;

  localparam logic [5:0] CHAR_SPACE  = 6'o40;
  localparam logic [5:0] CHAR_DIGIT0 = 6'o60;

  // Returns {valid, char_rom address}; valid=0 for keys with no glyph.
  function automatic logic [6:0] scan_to_char(input logic [7:0] code);
    logic [6:0] r;
    r = {1'b0, CHAR_SPACE};
    case (code)
      SC_A: r = {1'b1, 6'o01};
      SC_B: r = {1'b1, 6'o02};
      SC_C: r = {1'b1, 6'o03};
      SC_D: r = {1'b1, 6'o04};
      SC_E: r = {1'b1, 6'o05};
      SC_F: r = {1'b1, 6'o06};
      SC_G: r = {1'b1, 6'o07};
      SC_H: r = {1'b1, 6'o10};
      SC_I: r = {1'b1, 6'o11};
      SC_J: r = {1'b1, 6'o12};
      SC_K: r = {1'b1, 6'o13};
      SC_L: r = {1'b1, 6'o14};
      SC_M: r = {1'b1, 6'o15};
      SC_N: r = {1'b1, 6'o16};
      SC_O: r = {1'b1, 6'o17};
      SC_P: r = {1'b1, 6'o20};
      SC_Q: r = {1'b1, 6'o21};
      SC_R: r = {1'b1, 6'o22};
      SC_S: r = {1'b1, 6'o23};
      SC_T: r = {1'b1, 6'o24};
      SC_U: r = {1'b1, 6'o25};
      SC_V: r = {1'b1, 6'o26};
      SC_W: r = {1'b1, 6'o27};
      SC_X: r = {1'b1, 6'o30};
      SC_Y: r = {1'b1, 6'o31};
      SC_Z: r = {1'b1, 6'o32};
      SC_0: r = {1'b1, 6'o60};
      SC_1: r = {1'b1, 6'o61};
      SC_2: r = {1'b1, 6'o62};
      SC_3: r = {1'b1, 6'o63};
      SC_4: r = {1'b1, 6'o64};
      SC_5: r = {1'b1, 6'o65};
      SC_6: r = {1'b1, 6'o66};
      SC_7: r = {1'b1, 6'o67};
      SC_8: r = {1'b1, 6'o70};
      SC_9: r = {1'b1, 6'o71};
      default: r = {1'b0, CHAR_SPACE};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ps2_text_line_buffer_bcd_counter.sv
// Multi-digit BCD up-counter with ripple carry between digits.
// Every digit stays in 0..9; all-nines wraps to all-zeros in one step.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  Clock_50,
  input  logic                  Reset,
  input  logic                  Inc,
  output logic [4*DIGITS-1:0]   Bcd
);

  logic [4*DIGITS-1:0] digits_q, digits_d;
  logic                carry;

  // Next count: walk digits from LS upward, propagating the carry.
  always_comb begin
    digits_d = digits_q;
    carry    = Inc;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (digits_q[4*d +: 4] == 4'd9) begin
          digits_d[4*d +: 4] = 4'd0;
        end else begin
          digits_d[4*d +: 4] = digits_q[4*d +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clock_50) begin
    if (Reset) digits_q <= '0;
    else       digits_q <= digits_d;
  end

  assign Bcd = digits_q;

endmodule

// File: rtl/ps2_text_line_buffer.sv
// Editable text line driven by PS/2 make codes, plus a BCD run counter,
// rendered as char_rom addresses for the current 8x8 pixel cell.
// Build option: define TEXT_SCROLL_EN to scroll the line left when a
// printable key arrives with the buffer full (otherwise the key is dropped).
module ps2_text_line_buffer
  import ps2_text_pkg::*;
#(
  parameter int MSG_LEN    = 16,
  parameter int RUN_DIGITS = 2,
  parameter int RUN_LINE   = 280,
  parameter int TEXT_LINE  = 320,
  parameter int START_COL  = 360,
  localparam int CW        = $clog2(MSG_LEN + 1)
) (
  input  logic                    Clock_50,
  input  logic                    Reset,
  input  logic [7:0]              PS2_code,
  input  logic                    PS2_code_ready,
  input  logic                    PS2_make_code,
  input  logic [9:0]              Pixel_X_pos,
  input  logic [9:0]              Pixel_Y_pos,
  output logic [5:0]              Character_address,
  output logic [4*RUN_DIGITS-1:0] Run_bcd,
  output logic [CW-1:0]           Char_count,
  output logic                    Buffer_full
);

  localparam logic [6:0] RUN_ROW    = 7'(RUN_LINE / 8);
  localparam logic [6:0] TEXT_ROW   = 7'(TEXT_LINE / 8);
  localparam logic [6:0] START_CELL = 7'(START_COL / 8);

  logic          ready_q, ready_d;
  logic [5:0]    text_q [MSG_LEN];
  logic [5:0]    text_d [MSG_LEN];
  logic [CW-1:0] count_q, count_d;
  logic          key_evt;
  logic          run_inc;
  logic [6:0]    key_char;
  logic          full;

  assign key_evt  = PS2_code_ready & ~ready_q & PS2_make_code;
  assign key_char = scan_to_char(PS2_code);
  assign full     = (count_q == CW'(MSG_LEN));
  assign ready_d  = PS2_code_ready;

  // Apply one key event to the buffer/count; space also bumps the run counter.
  always_comb begin
    text_d  = text_q;
    count_d = count_q;
    run_inc = 1'b0;
    if (key_evt) begin
      if (PS2_code == SC_SPACE) begin
        run_inc = 1'b1;
        count_d = '0;
        for (int i = 0; i < MSG_LEN; i++) text_d[i] = CHAR_SPACE;
      end else if (PS2_code == SC_BKSP) begin
        if (count_q != '0) begin
          count_d = count_q - CW'(1);
          for (int i = 0; i < MSG_LEN; i++)
            if (CW'(i) == count_q - CW'(1)) text_d[i] = CHAR_SPACE;
        end
      end else if (key_char[6]) begin
        if (!full) begin
          count_d = count_q + CW'(1);
          for (int i = 0; i < MSG_LEN; i++)
            if (CW'(i) == count_q) text_d[i] = key_char[5:0];
        end else begin
`ifdef TEXT_SCROLL_EN
          for (int i = 0; i < MSG_LEN - 1; i++) text_d[i] = text_q[i+1];
          text_d[MSG_LEN-1] = key_char[5:0];
`else
          count_d = count_q;
`endif
        end
      end
    end
  end

  // State registers; reset takes priority over any key event.
  always_ff @(posedge Clock_50) begin
    if (Reset) begin
      ready_q <= 1'b0;
      count_q <= '0;
      for (int i = 0; i < MSG_LEN; i++) text_q[i] <= CHAR_SPACE;
    end else begin
      ready_q <= ready_d;
      count_q <= count_d;
      for (int i = 0; i < MSG_LEN; i++) text_q[i] <= text_d[i];
    end
  end

  bcd_counter #(.DIGITS(RUN_DIGITS)) u_run_cnt (
    .Clock_50 (Clock_50),
    .Reset    (Reset),
    .Inc      (run_inc),
    .Bcd      (Run_bcd)
  );

  logic [6:0]            cell_x, cell_y, k;
  logic [RUN_DIGITS-1:0] blank;
  logic                  lead;
  logic                  in_cols;
  logic                  unused_pix;

  assign cell_x     = Pixel_X_pos[9:3];
  assign cell_y     = Pixel_Y_pos[9:3];
  assign k          = cell_x - START_CELL;
  assign in_cols    = (cell_x >= START_CELL);
  assign unused_pix = ^{Pixel_X_pos[2:0], Pixel_Y_pos[2:0]};

  // Leading-zero blanking, MS digit downward; the LS digit is never blanked.
  always_comb begin
    blank = '0;
    lead  = 1'b1;
    for (int j = RUN_DIGITS - 1; j >= 1; j--) begin
      lead     = lead & (Run_bcd[4*j +: 4] == 4'd0);
      blank[j] = lead;
    end
  end

  // Cell lookup: "RUN nn" on the run row, buffer contents on the text row.
  always_comb begin
    Character_address = CHAR_SPACE;
    if (in_cols && cell_y == RUN_ROW) begin
      case (k)
        7'd0:    Character_address = 6'o22;
        7'd1:    Character_address = 6'o25;
        7'd2:    Character_address = 6'o16;
        default: Character_address = CHAR_SPACE;
      endcase
      for (int j = 0; j < RUN_DIGITS; j++)
        if (k == 7'(4 + RUN_DIGITS - 1 - j))
          Character_address = blank[j] ? CHAR_SPACE : {2'b11, Run_bcd[4*j +: 4]};
    end else if (in_cols && cell_y == TEXT_ROW) begin
      for (int i = 0; i < MSG_LEN; i++)
        if (k == 7'(i)) Character_address = text_q[i];
    end
  end

  assign Char_count  = count_q;
  assign Buffer_full = full;

endmodule

// File: tb/tb_ps2_text_line_buffer.sv
// Scoreboard bench for ps2_text_line_buffer: stimulus pushes expected values,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ps2_text_line_buffer;

  logic       Clock_50 = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] PS2_code = 8'h00;
  logic       PS2_code_ready = 1'b0;
  logic       PS2_make_code = 1'b0;
  logic [9:0] Pixel_X_pos = 10'd0;
  logic [9:0] Pixel_Y_pos = 10'd0;
  logic [5:0] Character_address;
  logic [7:0] Run_bcd;
  logic [4:0] Char_count;
  logic       Buffer_full;

  always #10 Clock_50 = ~Clock_50;

  ps2_text_line_buffer dut (
    .Clock_50          (Clock_50),
    .Reset             (Reset),
    .PS2_code          (PS2_code),
    .PS2_code_ready    (PS2_code_ready),
    .PS2_make_code     (PS2_make_code),
    .Pixel_X_pos       (Pixel_X_pos),
    .Pixel_Y_pos       (Pixel_Y_pos),
    .Character_address (Character_address),
    .Run_bcd           (Run_bcd),
    .Char_count        (Char_count),
    .Buffer_full       (Buffer_full)
  );

  typedef struct {
    string nm;
    int    kind;   // 0 cell address, 1 count, 2 full flag, 3 run bcd
    int    exp;
  } item_t;

  item_t sb[$];
  int checks = 0;
  int errors = 0;

  // Monitor: compares the oldest pending expectation away from the active edge.
  always @(negedge Clock_50) begin
    if (sb.size() > 0) begin
      item_t it;
      int got;
      it = sb.pop_front();
      case (it.kind)
        0:       got = int'(Character_address);
        1:       got = int'(Char_count);
        2:       got = int'(Buffer_full);
        default: got = int'(Run_bcd);
      endcase
      checks++;
      if (got != it.exp) begin
        errors++;
        $display("FAIL %s: got 'h%0h, expected 'h%0h", it.nm, got, it.exp);
      end
    end
  end

  task automatic expect_val(input string nm, input int kind, input int exp,
                            input int x, input int y);
    item_t it;
    Pixel_X_pos = 10'(x);
    Pixel_Y_pos = 10'(y);
    it.nm = nm; it.kind = kind; it.exp = exp;
    sb.push_back(it);
    for (int w = 0; w < 8 && sb.size() > 0; w++) @(posedge Clock_50);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: monitor timeout, got no compare, expected 'h%0h", nm, exp);
      sb.delete();
    end
  endtask

  task automatic chk(input string nm, input int kind, input int exp);
    expect_val(nm, kind, exp, 0, 0);
  endtask

  task automatic chk_text(input string nm, input int col, input int exp);
    expect_val(nm, 0, exp, 360 + 8*col, 320);
  endtask

  task automatic chk_run(input string nm, input int col, input int exp);
    expect_val(nm, 0, exp, 360 + 8*col, 280);
  endtask

  task automatic press(input logic [7:0] code, input logic make);
    @(posedge Clock_50); #1;
    PS2_code = code; PS2_make_code = make; PS2_code_ready = 1'b1;
    @(posedge Clock_50); #1;
    PS2_code_ready = 1'b0;
    @(posedge Clock_50); #1;
  endtask

  logic [7:0] letters [17] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                               8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                               8'h15};

  initial begin
    repeat (3) @(posedge Clock_50);
    #1 Reset = 1'b0;

    // Reset state and static display
    chk("reset_count", 1, 0);
    chk("reset_full", 2, 0);
    chk("reset_run", 3, 8'h00);
    chk_text("reset_text0", 0, 6'o40);
    chk_run("run_R", 0, 6'o22);
    chk_run("run_U", 1, 6'o25);
    chk_run("run_N", 2, 6'o16);
    chk_run("run_gap", 3, 6'o40);
    chk_run("run_ms_zero_blank", 4, 6'o40);
    chk_run("run_ls_zero", 5, 6'o60);
    chk("off_screen_cell", 0, 6'o40);

    // A, B, C
    press(8'h1C, 1'b1); press(8'h32, 1'b1); press(8'h21, 1'b1);
    chk("abc_count", 1, 3);
    chk_text("abc_cell0", 0, 6'o01);
    chk_text("abc_cell1", 1, 6'o02);
    chk_text("abc_cell2", 2, 6'o03);
    chk_text("abc_cell3", 3, 6'o40);
    chk_text("past_msg_len", 16, 6'o40);

    // Backspace down to empty, then A + two backspaces
    repeat (3) press(8'h66, 1'b1);
    chk("bksp_clear_count", 1, 0);
    press(8'h1C, 1'b1);
    chk_text("a_again_cell0", 0, 6'o01);
    press(8'h66, 1'b1);
    press(8'h66, 1'b1);
    chk("bksp_noop_count", 1, 0);
    chk_text("bksp_cell0", 0, 6'o40);

    // 17 letters into a 16-slot buffer
    foreach (letters[i]) press(letters[i], 1'b1);
    chk("full_count", 1, 16);
    chk("full_flag", 2, 1);
`ifdef TEXT_SCROLL_EN
    chk_text("full_cell0", 0, 6'o02);
    chk_text("full_cell15", 15, 6'o21);
`else
    chk_text("full_cell0", 0, 6'o01);
    chk_text("full_cell15", 15, 6'o20);
`endif
    press(8'h66, 1'b1);
    chk("full_bksp_count", 1, 15);
    chk("full_bksp_flag", 2, 0);

    // Space: run counter +1, buffer clears
    press(8'h29, 1'b1);
    chk("space_count", 1, 0);
    chk_text("space_cell0", 0, 6'o40);
    chk("space_run1", 3, 8'h01);
    for (int n = 2; n <= 100; n++) begin
      if (n == 50) press(8'h45, 1'b1);
      press(8'h29, 1'b1);
      case (n)
        5: begin
          chk("run05", 3, 8'h05);
          chk_run("run05_ms", 4, 6'o40);
          chk_run("run05_ls", 5, 6'o65);
        end
        9:  chk("run09", 3, 8'h09);
        10: begin
          chk("run10", 3, 8'h10);
          chk_run("run10_ms", 4, 6'o61);
          chk_run("run10_ls", 5, 6'o60);
        end
        50: chk("space_clears_digit", 1, 0);
        99: chk("run99", 3, 8'h99);
        100: begin
          chk("run_wrap", 3, 8'h00);
          chk_run("run00_ms", 4, 6'o40);
          chk_run("run00_ls", 5, 6'o60);
        end
        default: ;
      endcase
    end

    // Held ready level -> one event; break code ignored
    @(posedge Clock_50); #1;
    PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    repeat (50) @(posedge Clock_50);
    #1 PS2_code_ready = 1'b0;
    repeat (2) @(posedge Clock_50);
    #1;
    chk("hold_count", 1, 1);
    chk_text("hold_cell0", 0, 6'o01);
    press(8'h32, 1'b0);
    chk("break_count", 1, 1);
    chk_text("break_cell1", 1, 6'o40);
    press(8'h66, 1'b1);
    chk("unmapped_pre", 1, 0);
    press(8'h76, 1'b1);
    chk("unmapped_count", 1, 0);

    // Reset coincident with a key event
    press(8'h29, 1'b1);
    press(8'h1C, 1'b1);
    chk("pre_reset_run", 3, 8'h01);
    chk("pre_reset_count", 1, 1);
    @(posedge Clock_50); #1;
    Reset = 1'b1;
    PS2_code = 8'h32; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
    @(posedge Clock_50); #1;
    Reset = 1'b0;
    PS2_code_ready = 1'b0;
    chk("rst_win_count", 1, 0);
    chk("rst_win_run", 3, 8'h00);
    chk("rst_win_full", 2, 0);
    chk_text("rst_win_cell0", 0, 6'o40);

    repeat (2) @(posedge Clock_50);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
